// File: rtl/game_pkg.sv
// Shared encodings for the tunnel-game flow controller: FSM states,
// game_info bit positions and direction codes.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_PLAY      = 3'd2,
        ST_CRASH     = 3'd3,
        ST_OVER      = 3'd4
    } state_t;

    localparam int unsigned DIR_LSB   = 0;
    localparam int unsigned LEVEL_BIT = 4;
    localparam int unsigned PLAY_BIT  = 7;

    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_NONE  = 2'b00;

    // Conflicting or absent requests both mean "go straight".
    function automatic logic [1:0] dir_code(input logic left, input logic right);
        if (left && !right)
            return DIR_LEFT;
        else if (right && !left)
            return DIR_RIGHT;
        else
            return DIR_NONE;
    endfunction

endpackage

// File: rtl/frame_divider.sv
// Modulo-N frame_tick counter with synchronous clear; term pulses on the N-th tick.
// Latency: term is combinational on the terminal tick. No backpressure: tick is a pulse.
// Backpressure: none, counts every enabled tick; clear has priority over tick.
module frame_divider #(
    parameter int unsigned N = 60,
    localparam int unsigned W = (N > 1) ? $clog2(N) : 1
) (
    input  logic clock,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    output logic term
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] count;

    assign term = tick && (count == LAST);

    always_ff @(posedge clock) begin
        if (rst || clear)
            count <= '0;
        else if (tick)
            count <= term ? '0 : count + W'(1);
    end

endmodule

// File: rtl/game_sequencer.sv
// Game-flow controller: idle/countdown/play/crash/over, score, level, game_info word.
// Latency: game_info/video_rst/score registered, one cycle after inputs. No backpressure.
// Optional: GAME_SEQ_HIGH_SCORE_EN adds a high_score register and port.
module game_sequencer
    import game_pkg::*;
#(
    parameter int unsigned FRAMES_PER_STEP = 60,
    parameter int unsigned SCORE_DIV       = 6,
    parameter int unsigned LEVEL_UP_SCORE  = 500,
    parameter int unsigned CRASH_FRAMES    = 120
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_start,
    input  logic        frame_tick,
    input  logic        collision,
    output logic [7:0]  game_info,
    output logic        video_rst,
    output logic [15:0] score,
    output logic [1:0]  countdown,
    output logic        game_over,
    output logic [2:0]  state_dbg
`ifdef GAME_SEQ_HIGH_SCORE_EN
    ,
    output logic [15:0] high_score
`endif
);

    state_t      state, state_nxt;
    logic        start_q;
    logic        start_rise;
    logic        start_game;
    logic        state_change;
    logic [1:0]  step_idx;
    logic        level, level_nxt;
    logic [15:0] score_nxt;
    logic [7:0]  game_info_nxt;
    logic        step_term, score_term, crash_term;

    assign start_rise   = btn_start && !start_q;
    assign start_game   = start_rise && (state == ST_IDLE || state == ST_OVER);
    assign state_change = (state_nxt != state);

    // Clearing on every transition means a tick in the entry cycle never counts.
    frame_divider #(.N(FRAMES_PER_STEP)) u_step_div (
        .clock (clock),
        .rst   (rst),
        .clear (state_change),
        .tick  (frame_tick && state == ST_COUNTDOWN),
        .term  (step_term)
    );

    frame_divider #(.N(SCORE_DIV)) u_score_div (
        .clock (clock),
        .rst   (rst),
        .clear (state_change),
        .tick  (frame_tick && state == ST_PLAY),
        .term  (score_term)
    );

    frame_divider #(.N(CRASH_FRAMES)) u_crash_div (
        .clock (clock),
        .rst   (rst),
        .clear (state_change),
        .tick  (frame_tick && state == ST_CRASH),
        .term  (crash_term)
    );

    always_ff @(posedge clock) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        score_nxt     = score;
        level_nxt     = level;
        game_info_nxt = 8'h00;

        case (state)
            ST_IDLE:      if (start_rise) state_nxt = ST_COUNTDOWN;
            ST_COUNTDOWN: if (step_term && step_idx == 2'd2) state_nxt = ST_PLAY;
            ST_PLAY:      if (collision) state_nxt = ST_CRASH;
            ST_CRASH:     if (crash_term) state_nxt = ST_OVER;
            ST_OVER:      if (start_rise) state_nxt = ST_COUNTDOWN;
            default:      state_nxt = ST_IDLE;
        endcase

        // A collision in the same cycle as a due increment drops the increment.
        if (start_game)
            score_nxt = 16'h0000;
        else if (state == ST_PLAY && score_term && !collision && score != 16'hFFFF)
            score_nxt = score + 16'd1;

        if (start_game)
            level_nxt = 1'b0;
        else if (score_nxt >= 16'(LEVEL_UP_SCORE))
            level_nxt = 1'b1;

        if (state_nxt == ST_PLAY) begin
            game_info_nxt[DIR_LSB +: 2] = dir_code(btn_left, btn_right);
            game_info_nxt[PLAY_BIT]     = 1'b1;
        end
        game_info_nxt[LEVEL_BIT] = level_nxt;
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            start_q   <= 1'b0;
            step_idx  <= 2'd0;
            score     <= 16'h0000;
            level     <= 1'b0;
            game_info <= 8'h00;
            video_rst <= 1'b0;
        end else begin
            start_q   <= btn_start;
            score     <= score_nxt;
            level     <= level_nxt;
            game_info <= game_info_nxt;
            video_rst <= state_change && (state_nxt == ST_COUNTDOWN);
            if (state_change)
                step_idx <= 2'd0;
            else if (step_term)
                step_idx <= step_idx + 2'd1;
        end
    end

`ifdef GAME_SEQ_HIGH_SCORE_EN
    always_ff @(posedge clock) begin
        if (rst)
            high_score <= 16'h0000;
        else if (state_change && state_nxt == ST_OVER && score > high_score)
            high_score <= score;
    end
`endif

    assign countdown = (state == ST_COUNTDOWN) ? (2'd3 - step_idx) : 2'd0;
    assign game_over = (state == ST_OVER);
    assign state_dbg = state;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: countdown, steering, scoring, crash, restart, reset.
// Optional high_score checks follow GAME_SEQ_HIGH_SCORE_EN.
module tb_game_sequencer;

    logic        clock = 1'b0;
    logic        rst;
    logic        btn_left, btn_right, btn_start;
    logic        frame_tick, collision;
    logic [7:0]  game_info;
    logic        video_rst;
    logic [15:0] score;
    logic [1:0]  countdown;
    logic        game_over;
    logic [2:0]  state_dbg;
`ifdef GAME_SEQ_HIGH_SCORE_EN
    logic [15:0] high_score;
`endif

    int total = 0;
    int bad   = 0;
    int pulses;

    game_sequencer dut (
        .clock      (clock),
        .rst        (rst),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_start  (btn_start),
        .frame_tick (frame_tick),
        .collision  (collision),
        .game_info  (game_info),
        .video_rst  (video_rst),
        .score      (score),
        .countdown  (countdown),
        .game_over  (game_over),
        .state_dbg  (state_dbg)
`ifdef GAME_SEQ_HIGH_SCORE_EN
        ,
        .high_score (high_score)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            step();
        end
    endtask

    initial begin
        rst = 1'b1;
        btn_left = 1'b0; btn_right = 1'b0; btn_start = 1'b0;
        frame_tick = 1'b0; collision = 1'b0;
        repeat (3) step();
        check("rst_state", state_dbg, 0);
        check("rst_info", game_info, 0);
        check("rst_vrst", video_rst, 0);
        check("rst_score", score, 0);
        check("rst_cd", countdown, 0);
        check("rst_over", game_over, 0);
        rst = 1'b0;
        step();
        check("idle_state", state_dbg, 0);

        // Game 1: countdown, steering, collision on a due increment
        btn_start = 1'b1;
        step();
        check("cd_enter", state_dbg, 1);
        check("vrst_pulse", video_rst, 1);
        check("cd3_first", countdown, 3);
        btn_start = 1'b0;
        step();
        check("vrst_single", video_rst, 0);
        tick(59);  check("cd3_last", countdown, 3);
        tick(1);   check("cd2_first", countdown, 2);
        tick(59);  check("cd2_last", countdown, 2);
        tick(1);   check("cd1_first", countdown, 1);
        tick(59);  check("cd_still", state_dbg, 1);
        tick(1);
        check("play_enter", state_dbg, 2);
        check("play_cd0", countdown, 0);
        check("play_info", game_info, 8'h80);

        btn_left = 1'b1;  step(); check("dir_left", game_info, 8'h82);
        btn_right = 1'b1; step(); check("dir_both", game_info, 8'h80);
        btn_left = 1'b0;  step(); check("dir_right", game_info, 8'h81);
        btn_right = 1'b0; step(); check("dir_none", game_info, 8'h80);

        tick(65);
        check("score10", score, 10);
        collision = 1'b1;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        check("crash_enter", state_dbg, 3);
        check("crash_drop_inc", score, 10);
        check("crash_info", game_info, 8'h00);
        btn_left = 1'b1; btn_right = 1'b1;
        step();
        check("crash_btns", game_info, 8'h00);
        btn_left = 1'b0; btn_right = 1'b0;
        tick(119); check("crash_hold", state_dbg, 3);
        tick(1);
        check("over_enter", state_dbg, 4);
        check("over_flag", game_over, 1);
        check("over_score", score, 10);
`ifdef GAME_SEQ_HIGH_SCORE_EN
        check("hs_game1", high_score, 10);
`endif
        collision = 1'b0;

        // Restart with start held for 10 cycles
        pulses = 0;
        btn_start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (video_rst) pulses++;
        end
        btn_start = 1'b0;
        check("restart_pulses", pulses, 1);
        check("restart_state", state_dbg, 1);
        check("restart_score", score, 0);
        check("restart_cd", countdown, 3);
        check("restart_info", game_info, 8'h00);
        check("restart_over", game_over, 0);

        // Game 2: level-up boundary
        tick(180);
        check("g2_play", state_dbg, 2);
        tick(2994);
        check("g2_score499", score, 499);
        check("g2_lvl0", game_info, 8'h80);
        tick(5);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        check("g2_score500", score, 500);
        check("g2_lvl1", game_info, 8'h90);
        step();
`ifdef GAME_SEQ_HIGH_SCORE_EN
        check("hs_held_in_play", high_score, 10);
`endif
        collision = 1'b1;
        step();
        check("g2_crash", state_dbg, 3);
        check("g2_crash_info", game_info, 8'h10);
        tick(120);
        check("g2_over", state_dbg, 4);
        check("g2_score", score, 500);
`ifdef GAME_SEQ_HIGH_SCORE_EN
        check("hs_game2", high_score, 500);
`endif
        collision = 1'b0;

        // Game 3: lower score must not lower the high score
        btn_start = 1'b1;
        step();
        btn_start = 1'b0;
        check("g3_lvl_clear", game_info, 8'h00);
        tick(180);
        tick(222);
        check("g3_score37", score, 37);
        collision = 1'b1;
        step();
        tick(120);
        collision = 1'b0;
        check("g3_over", state_dbg, 4);
        check("g3_score", score, 37);
`ifdef GAME_SEQ_HIGH_SCORE_EN
        check("hs_game3", high_score, 500);
`endif

        // Game 4: start coincident with frame_tick, then reset mid-play
        btn_start = 1'b1;
        frame_tick = 1'b1;
        step();
        btn_start = 1'b0;
        frame_tick = 1'b0;
        check("g4_cd", state_dbg, 1);
        tick(179);
        check("g4_cd_hold", state_dbg, 1);
        check("g4_cd1", countdown, 1);
        tick(1);
        check("g4_play", state_dbg, 2);
        tick(222);
        check("g4_score37", score, 37);
        btn_left = 1'b1;
        rst = 1'b1;
        step();
        check("mid_rst_state", state_dbg, 0);
        check("mid_rst_info", game_info, 0);
        check("mid_rst_score", score, 0);
        check("mid_rst_cd", countdown, 0);
        check("mid_rst_over", game_over, 0);
        check("mid_rst_vrst", video_rst, 0);
`ifdef GAME_SEQ_HIGH_SCORE_EN
        check("mid_rst_hs", high_score, 0);
`endif
        rst = 1'b0;
        btn_left = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Top-level game-flow controller for the tunnel game.
- Sequences idle, countdown, play, crash and game-over phases.
- Turns player buttons into the 8-bit game_info control word consumed by video_game_controller.
- Keeps score and level, and issues a one-cycle restart pulse to the video controller so bot position, wall and sticky collision flag clear between games.

Parameters:
- FRAMES_PER_STEP, 60: frame_ticks per countdown step (3 steps).
- SCORE_DIV, 6: frame_ticks in PLAY per score increment.
- LEVEL_UP_SCORE, 500: score at or above which fast level is selected.
- CRASH_FRAMES, 120: frame_ticks spent in CRASH before OVER.

Ports:
- clock  in  1  25 MHz pixel clock.
- rst  in  1  synchronous, active-high reset.
- btn_left  in  1  debounced level, move-left request.
- btn_right  in  1  debounced level, move-right request.
- btn_start  in  1  debounced level, start/restart request.
- frame_tick  in  1  one-cycle pulse per frame (pixel row 0, column 0).
- collision  in  1  sticky collision flag from video controller.
- game_info  out  8  control word to video controller.
- video_rst  out  1  one-cycle restart pulse to video controller.
- score  out  16  binary score.
- countdown  out  2  3/2/1 during COUNTDOWN, else 0.
- game_over  out  1  high in OVER.
- state_dbg  out  3  current state encoding.

Behaviour:
- Reset: state IDLE; game_info=0, video_rst=0, score=0, countdown=0, game_over=0, level=0, all counters 0. Reset mid-game aborts immediately to IDLE with the same values.
- State encoding: IDLE=0, COUNTDOWN=1, PLAY=2, CRASH=3, OVER=4.
- Start edge: start_rise = btn_start & ~btn_start_q (registered copy). Holding start does not retrigger.
- IDLE: on start_rise go to COUNTDOWN, pulse video_rst next cycle, clear score, level and counters.
- COUNTDOWN: step counter counts frame_ticks.
  - countdown = 3 for the first FRAMES_PER_STEP ticks, then 2, then 1.
  - On the 3*FRAMES_PER_STEP-th tick go to PLAY; countdown becomes 0.
  - collision is ignored in this state.
- PLAY: divider counts frame_ticks.
  - On the SCORE_DIV-th tick: score += 1, saturating at 16'hFFFF; divider wraps to 0.
  - level set to 1 once score >= LEVEL_UP_SCORE; it stays set until the next game.
  - collision=1 in any cycle: go to CRASH. Score is frozen; an increment due in the same cycle is dropped (collision wins).
- CRASH: counts CRASH_FRAMES frame_ticks, then goes to OVER. Buttons ignored.
- OVER: game_over=1. start_rise behaves as in IDLE (COUNTDOWN plus video_rst pulse). Score is held until then.
- game_info, all bits registered (one cycle after inputs):
  - [1:0] direction, only in PLAY: left-only=2'b10, right-only=2'b01, both or neither=2'b00. Forced to 00 outside PLAY.
  - [4] = level.
  - [7] = 1 in PLAY.
  - [3:2], [6:5] = 0.
- video_rst: exactly one cycle, registered, asserted the cycle after the transition into COUNTDOWN.
- Counters: step/divider/crash counters sized by $clog2 of their parameter; cleared on every state entry.
- frame_tick and start_rise in the same cycle: start_rise is acted on; a frame_tick in the entry cycle does not count toward the new state.

Optional Feature:
- Macro: GAME_SEQ_HIGH_SCORE_EN.
- With the macro: adds output high_score[15:0], reset to 0. On entry to OVER, high_score = max(high_score, score). Survives restarts; cleared only by rst.
- Without the macro: no port, no register.

Decomposition:
- Shared package game_pkg holds:
  - state encoding constants;
  - game_info bit-position constants (DIR_LSB=0, LEVEL_BIT=4, PLAY_BIT=7);
  - direction codes DIR_LEFT=2'b10, DIR_RIGHT=2'b01, DIR_NONE=2'b00.
- One natural sub-module: frame_divider. A frame_tick-enabled modulo-N counter with clear and a terminal pulse, instanced three times (countdown step, score, crash).

Test Plan:
- Reset then btn_start high 1 cycle -> COUNTDOWN; video_rst single pulse next cycle; countdown 3→2→1 at frame 0/60/120; PLAY at tick 180, game_info[7]=1.
- PLAY with btn_left=1 -> game_info[1:0]=10; add btn_right=1 -> 00; release left -> 01; in CRASH any buttons -> 00.
- PLAY for 3000 frame_ticks, no collision -> score=500; game_info[4]=1 from the cycle score reaches 500.
- collision asserted same cycle as the 6th frame_tick, score=10 -> score stays 10; CRASH; OVER after 120 ticks; game_over=1.
- OVER, btn_start held 10 cycles -> exactly one video_rst pulse; score=0, level=0, countdown=3.
- rst asserted mid-PLAY with score=37 -> next cycle IDLE, all outputs 0; with GAME_SEQ_HIGH_SCORE_EN, high_score=max across two games (e.g. 42 then 17 → 42).
